// File: rtl/cisr_pkg.sv
// Shared types and default widths for the CISR row accumulator and its decoder.
// Result records are {rowID, sum, lane}; the per-lane FIFO is sized for a two-push beat.
package cisr_pkg;

    localparam int LANES  = 4;
    localparam int ROW_W  = 5;
    localparam int DATA_W = 32;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;
    // a row change with last pushes two results, so keep two slots free before accepting
    localparam logic [CNT_W-1:0] FIFO_READY_MAX = CNT_W'(FIFO_DEPTH - 2);

    typedef struct packed {
        logic [ROW_W-1:0]  rowID;
        logic [DATA_W-1:0] sum;
        logic [LANE_W-1:0] lane;
    } result_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } laneState_t;

endpackage

// File: rtl/cisr_lane_accum.sv
// One decoder lane: accumulates products of consecutive beats sharing a row ID and
// queues closed rows in a 4-entry FIFO for the output arbiter.
//
//   state | meaning
//   IDLE  | no open row; next accepted beat starts one
//   ACCUM | row curRow open, running sum in acc
module cisr_lane_accum
    import cisr_pkg::*;
#(
    parameter int RowW  = 5,
    parameter int DataW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beatValid,
    output logic             beatReady,
    input  logic [RowW-1:0]  beatRowID,
    input  logic [DataW-1:0] beatValue,
    input  logic             beatLast,
    output logic             headValid,
    output logic [RowW-1:0]  headRowID,
    output logic [DataW-1:0] headSum,
    input  logic             pop
);

    laneState_t       state, stateNext;
    logic [RowW-1:0]  curRow, curRowNext;
    logic [DataW-1:0] acc, accNext;

    logic             accept;
    logic             sameRow;
    logic [DataW-1:0] beatSum;

    logic             push0, push1;
    logic [RowW-1:0]  pushRow0, pushRow1;
    logic [DataW-1:0] pushSum0, pushSum1;
    logic [CNT_W-1:0] pushCnt;
    logic             popEff;

    logic [RowW-1:0]  memRow [FIFO_DEPTH];
    logic [DataW-1:0] memSum [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count;

    // ready looks only at the registered count, so a same-cycle pop never opens it early
    assign beatReady = reset & (count <= FIFO_READY_MAX);
    assign accept    = beatValid & beatReady;
    assign sameRow   = (beatRowID == curRow);
    assign beatSum   = acc + beatValue;

    always_comb begin
        stateNext  = state;
        curRowNext = curRow;
        accNext    = acc;
        push0      = 1'b0;
        push1      = 1'b0;
        pushRow0   = curRow;
        pushSum0   = acc;
        pushRow1   = beatRowID;
        pushSum1   = beatValue;
        if (accept) begin
            curRowNext = beatRowID;
            stateNext  = beatLast ? IDLE : ACCUM;
            if (state == IDLE) begin
                accNext  = beatValue;
                push0    = beatLast;
                pushRow0 = beatRowID;
                pushSum0 = beatValue;
            end else if (sameRow) begin
                accNext  = beatSum;
                push0    = beatLast;
                pushSum0 = beatSum;
            end else begin
                accNext = beatValue;
                push0   = 1'b1;
                push1   = beatLast;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            curRow <= '0;
            acc    <= '0;
        end else begin
            state  <= stateNext;
            curRow <= curRowNext;
            acc    <= accNext;
        end
    end

    assign pushCnt = CNT_W'(push0) + CNT_W'(push1);
    assign popEff  = pop & headValid;

    always_ff @(posedge clk) begin
        if (push0) begin
            memRow[wrPtr] <= pushRow0;
            memSum[wrPtr] <= pushSum0;
        end
        if (push1) begin
            memRow[wrPtr + PTR_W'(1)] <= pushRow1;
            memSum[wrPtr + PTR_W'(1)] <= pushSum1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + PTR_W'(pushCnt);
            rdPtr <= rdPtr + PTR_W'(popEff);
            count <= count + pushCnt - CNT_W'(popEff);
        end
    end

    assign headValid = (count != '0);
    assign headRowID = memRow[rdPtr];
    assign headSum   = memSum[rdPtr];

endmodule

// File: rtl/cisr_row_accumulator.sv
// Row accumulator top: one cisr_lane_accum per decoder lane, a round-robin arbiter over
// non-empty lane FIFOs, and a single output register with valid/ready handshake.
module cisr_row_accumulator #(
    parameter int LANES  = cisr_pkg::LANES,
    parameter int ROW_W  = cisr_pkg::ROW_W,
    parameter int DATA_W = cisr_pkg::DATA_W,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        in_valid,
    output logic [LANES-1:0]        in_ready,
    input  logic [LANES*ROW_W-1:0]  in_rowID,
    input  logic [LANES*DATA_W-1:0] in_value,
    input  logic [LANES-1:0]        in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROW_W-1:0]        out_rowID,
    output logic [DATA_W-1:0]       out_sum,
    output logic [LANE_W-1:0]       out_lane
);

    logic [LANES-1:0]  headValid;
    logic [LANES-1:0]  pop;
    logic [ROW_W-1:0]  headRowID [LANES];
    logic [DATA_W-1:0] headSum   [LANES];

    logic [LANE_W-1:0] rrPtr;
    logic [LANE_W-1:0] grant;
    logic              anyHead;
    logic              load;

    for (genvar k = 0; k < LANES; k++) begin : gLane
        cisr_lane_accum #(
            .RowW  (ROW_W),
            .DataW (DATA_W)
        ) uLane (
            .clk       (clk),
            .reset     (reset),
            .beatValid (in_valid[k]),
            .beatReady (in_ready[k]),
            .beatRowID (in_rowID[k*ROW_W +: ROW_W]),
            .beatValue (in_value[k*DATA_W +: DATA_W]),
            .beatLast  (in_last[k]),
            .headValid (headValid[k]),
            .headRowID (headRowID[k]),
            .headSum   (headSum[k]),
            .pop       (pop[k])
        );
    end

    // scan from the far end so the lane closest to rrPtr wins
    always_comb begin
        grant   = rrPtr;
        anyHead = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (headValid[(int'(rrPtr) + i) % LANES]) begin
                grant   = LANE_W'((int'(rrPtr) + i) % LANES);
                anyHead = 1'b1;
            end
        end
    end

    assign load = anyHead & (~out_valid | out_ready);

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop[k] = load && (grant == LANE_W'(k));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_rowID <= '0;
            out_sum   <= '0;
            out_lane  <= '0;
            rrPtr     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_rowID <= headRowID[grant];
            out_sum   <= headSum[grant];
            out_lane  <= grant;
            rrPtr     <= (grant == LANE_W'(LANES - 1)) ? '0 : grant + LANE_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cisr_row_accumulator.sv
// Bench for cisr_row_accumulator: directed scenarios plus a randomized run scored
// against a row-sum reference model with per-lane ordering.
module tb_cisr_row_accumulator;
    import cisr_pkg::*;

    localparam int L  = LANES;
    localparam int RW = ROW_W;
    localparam int DW = DATA_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [L-1:0]        in_valid;
    logic [L-1:0]        in_ready;
    logic [L*RW-1:0]     in_rowID;
    logic [L*DW-1:0]     in_value;
    logic [L-1:0]        in_last;
    logic                out_valid;
    logic                out_ready;
    logic [RW-1:0]       out_rowID;
    logic [DW-1:0]       out_sum;
    logic [LANE_W-1:0]   out_lane;

    always #5 clk = ~clk;

    cisr_row_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rowID  (in_rowID),
        .in_value  (in_value),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rowID (out_rowID),
        .out_sum   (out_sum),
        .out_lane  (out_lane)
    );

    typedef struct {
        result_t res;
        int      cyc;
    } obs_t;

    obs_t    obsQ[$];
    result_t expQ[$];
    bit            modOpen [L];
    logic [RW-1:0] modRow  [L];
    logic [DW-1:0] modAcc  [L];
    int            acceptCnt [L];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic result_t mkRes(input int row, input logic [DW-1:0] sum, input int lane);
        result_t r;
        r.rowID = RW'(row);
        r.sum   = sum;
        r.lane  = LANE_W'(lane);
        return r;
    endfunction

    // reference: a row is the run of accepted beats sharing an ID, closed by a new ID or last
    task automatic modelBeat(input int k, input logic [RW-1:0] row, input logic [DW-1:0] val, input bit last);
        if (modOpen[k] && row != modRow[k]) expQ.push_back(mkRes(int'(modRow[k]), modAcc[k], k));
        if (modOpen[k] && row == modRow[k]) modAcc[k] = modAcc[k] + val;
        else begin
            modRow[k] = row;
            modAcc[k] = val;
        end
        modOpen[k] = 1'b1;
        if (last) begin
            expQ.push_back(mkRes(int'(modRow[k]), modAcc[k], k));
            modOpen[k] = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = '0;
        in_last  = '0;
        in_rowID = '0;
        in_value = '0;
    endtask

    task automatic driveBeat(input int k, input int row, input logic [DW-1:0] val, input bit last);
        in_valid[k]           = 1'b1;
        in_rowID[k*RW +: RW]  = RW'(row);
        in_value[k*DW +: DW]  = val;
        in_last[k]            = last;
    endtask

    task automatic cycle();
        obs_t o;
        #1;
        if (out_valid && out_ready) begin
            o.res.rowID = out_rowID;
            o.res.sum   = out_sum;
            o.res.lane  = out_lane;
            o.cyc       = cyc;
            obsQ.push_back(o);
        end
        for (int k = 0; k < L; k++) begin
            if (in_valid[k] && in_ready[k]) begin
                acceptCnt[k]++;
                modelBeat(k, in_rowID[k*RW +: RW], in_value[k*DW +: DW], in_last[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clearModel();
        obsQ.delete();
        expQ.delete();
        for (int k = 0; k < L; k++) begin
            modOpen[k]   = 1'b0;
            modRow[k]    = '0;
            modAcc[k]    = '0;
            acceptCnt[k] = 0;
        end
    endtask

    task automatic doReset();
        reset     = 1'b0;
        out_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clearModel();
    endtask

    task automatic test_reset();
        in_valid = '1;
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_rowID !== '0) begin failures++; $display("FAIL reset_out_rowID: got %h want 0", out_rowID); end
        checks++; if (out_sum !== '0) begin failures++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
        checks++; if (out_lane !== '0) begin failures++; $display("FAIL reset_out_lane: got %h want 0", out_lane); end
        checks++; if (in_ready !== '0) begin failures++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        idle();
    endtask

    task automatic test_basic();
        int lastCyc;
        doReset();
        out_ready = 1'b1;
        driveBeat(0, 0, 32'd1, 1'b0); cycle();
        driveBeat(0, 0, 32'd2, 1'b0); cycle();
        driveBeat(0, 0, 32'd3, 1'b0); cycle();
        driveBeat(0, 4, 32'd5, 1'b1); lastCyc = cyc; cycle();
        idle();
        repeat (6) cycle();
        checks++; if (obsQ.size() != 2) begin failures++; $display("FAIL basic_count: got %0d want 2", obsQ.size()); end
        if (obsQ.size() >= 2) begin
            checks++; if (obsQ[0].res !== mkRes(0, 32'd6, 0)) begin failures++; $display("FAIL basic_first: got %h want %h", obsQ[0].res, mkRes(0, 32'd6, 0)); end
            checks++; if (obsQ[1].res !== mkRes(4, 32'd5, 0)) begin failures++; $display("FAIL basic_second: got %h want %h", obsQ[1].res, mkRes(4, 32'd5, 0)); end
            checks++; if (obsQ[0].cyc != lastCyc + 2) begin failures++; $display("FAIL basic_latency: got cycle %0d want %0d", obsQ[0].cyc, lastCyc + 2); end
            checks++; if (obsQ[1].cyc != lastCyc + 3) begin failures++; $display("FAIL basic_back_to_back: got cycle %0d want %0d", obsQ[1].cyc, lastCyc + 3); end
        end
    endtask

    task automatic test_parallel();
        int rows [4] = '{0, 3, 5, 9};
        int beatCyc;
        doReset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) driveBeat(k, rows[k], DW'(100 + k), 1'b1);
        beatCyc = cyc;
        cycle();
        idle();
        repeat (8) cycle();
        checks++; if (obsQ.size() != 4) begin failures++; $display("FAIL parallel_count: got %0d want 4", obsQ.size()); end
        for (int i = 0; i < 4 && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i].res !== mkRes(rows[i], DW'(100 + i), i)) begin failures++; $display("FAIL parallel_result%0d: got %h want %h", i, obsQ[i].res, mkRes(rows[i], DW'(100 + i), i)); end
            checks++; if (obsQ[i].cyc != beatCyc + 2 + i) begin failures++; $display("FAIL parallel_cycle%0d: got %0d want %0d", i, obsQ[i].cyc, beatCyc + 2 + i); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals [6];
        for (int i = 0; i < 6; i++) vals[i] = $urandom;
        doReset();
        for (int t = 0; t < 12; t++) begin
            if (acceptCnt[2] < 6) driveBeat(2, 10 + acceptCnt[2], vals[acceptCnt[2]], 1'b1);
            else idle();
            cycle();
            if (out_valid) begin
                checks++;
                if (out_sum !== vals[0] || out_rowID !== RW'(10) || out_lane !== LANE_W'(2)) begin
                    failures++;
                    $display("FAIL bp_hold: got row=%0d sum=%h lane=%0d want row=10 sum=%h lane=2", out_rowID, out_sum, out_lane, vals[0]);
                end
            end
        end
        checks++; if (acceptCnt[2] != 4) begin failures++; $display("FAIL bp_accepted: got %0d want 4", acceptCnt[2]); end
        checks++; if (in_ready[2] !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready[2]); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            if (acceptCnt[2] < 6) driveBeat(2, 10 + acceptCnt[2], vals[acceptCnt[2]], 1'b1);
            else idle();
            cycle();
        end
        checks++; if (obsQ.size() != 6) begin failures++; $display("FAIL bp_count: got %0d want 6", obsQ.size()); end
        for (int i = 0; i < 6 && i < obsQ.size(); i++) begin
            checks++; if (obsQ[i].res !== mkRes(10 + i, vals[i], 2)) begin failures++; $display("FAIL bp_result%0d: got %h want %h", i, obsQ[i].res, mkRes(10 + i, vals[i], 2)); end
        end
    endtask

    task automatic test_overflow();
        doReset();
        out_ready = 1'b1;
        driveBeat(1, 7, 32'h7FFF_FFFF, 1'b0); cycle();
        driveBeat(1, 7, 32'h0000_0002, 1'b1); cycle();
        idle();
        repeat (5) cycle();
        checks++; if (obsQ.size() != 1) begin failures++; $display("FAIL wrap_count: got %0d want 1", obsQ.size()); end
        if (obsQ.size() >= 1) begin
            checks++; if (obsQ[0].res !== mkRes(7, 32'h8000_0001, 1)) begin failures++; $display("FAIL wrap_sum: got %h want %h", obsQ[0].res, mkRes(7, 32'h8000_0001, 1)); end
        end
    endtask

    task automatic test_rowchange_last();
        doReset();
        out_ready = 1'b1;
        driveBeat(3, 1, 32'd4, 1'b0); cycle();
        driveBeat(3, 2, 32'd6, 1'b1); cycle();
        idle();
        repeat (6) cycle();
        checks++; if (obsQ.size() != 2) begin failures++; $display("FAIL change_last_count: got %0d want 2", obsQ.size()); end
        if (obsQ.size() >= 2) begin
            checks++; if (obsQ[0].res !== mkRes(1, 32'd4, 3)) begin failures++; $display("FAIL change_last_old: got %h want %h", obsQ[0].res, mkRes(1, 32'd4, 3)); end
            checks++; if (obsQ[1].res !== mkRes(2, 32'd6, 3)) begin failures++; $display("FAIL change_last_new: got %h want %h", obsQ[1].res, mkRes(2, 32'd6, 3)); end
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        driveBeat(1, 2, 32'd11, 1'b1); cycle();
        idle();
        driveBeat(1, 6, 32'd22, 1'b1); cycle();
        idle();
        driveBeat(0, 8, 32'd33, 1'b0); cycle();
        idle();
        cycle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clearModel();
        out_ready = 1'b1;
        repeat (8) cycle();
        checks++; if (obsQ.size() != 0) begin failures++; $display("FAIL midrst_stale: got %0d results want 0", obsQ.size()); end
        driveBeat(0, 8, 32'd7, 1'b1); cycle();
        idle();
        repeat (5) cycle();
        checks++; if (obsQ.size() != 1) begin failures++; $display("FAIL midrst_after_count: got %0d want 1", obsQ.size()); end
        if (obsQ.size() >= 1) begin
            checks++; if (obsQ[0].res !== mkRes(8, 32'd7, 0)) begin failures++; $display("FAIL midrst_after: got %h want %h", obsQ[0].res, mkRes(8, 32'd7, 0)); end
        end
    endtask

    task automatic test_random();
        doReset();
        for (int t = 0; t < 800; t++) begin
            for (int k = 0; k < L; k++) begin
                in_valid[k]          = ($urandom_range(0, 99) < 60);
                in_rowID[k*RW +: RW] = RW'($urandom_range(0, 3));
                in_value[k*DW +: DW] = $urandom;
                in_last[k]           = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 99) < 65);
            cycle();
        end
        idle();
        out_ready = 1'b1;
        repeat (60) cycle();
        for (int i = 0; i < obsQ.size(); i++) begin
            int j;
            j = -1;
            for (int m = 0; m < expQ.size(); m++) begin
                if (expQ[m].lane == obsQ[i].res.lane) begin
                    j = m;
                    break;
                end
            end
            checks++;
            if (j < 0) begin
                failures++;
                $display("FAIL rand_unexpected: got %h want none pending for lane %0d", obsQ[i].res, obsQ[i].res.lane);
            end else begin
                if (obsQ[i].res !== expQ[j]) begin
                    failures++;
                    $display("FAIL rand_result%0d: got %h want %h", i, obsQ[i].res, expQ[j]);
                end
                expQ.delete(j);
            end
        end
        checks++; if (expQ.size() != 0) begin failures++; $display("FAIL rand_missing: got %0d undelivered want 0", expQ.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        idle();
        clearModel();
        #2;
        test_reset();
        test_basic();
        test_parallel();
        test_backpressure();
        test_overflow();
        test_rowchange_last();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
